// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the 16-entry register bank and its write-side blocks.
`timescale 1ns/1ps
package regbank_pkg;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int unsigned RESET_VAL = 0;

    function automatic logic [NUM_REGS-1:0] onehot16(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/write_decode_16.sv
// 4-to-16 one-hot write enable decoder, gated by the write request.
`timescale 1ns/1ps
module write_decode_16
    import regbank_pkg::*;
#(
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    output logic [NUM_REGS-1:0] wen_o
);
    always_comb begin
        wen_o = we_i ? onehot16(waddr_i) : '0;
        // A hard-wired zero register never sees a write enable.
        if (ZERO_REG) begin
            wen_o[0] = 1'b0;
        end
    end
endmodule

// File: rtl/register_bank_16.sv
// 16 x WIDTH register bank: one decoded write port, two registered read ports with write bypass.
`timescale 1ns/1ps
module register_bank_16
    import regbank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WE,
    input  logic [ADDR_W-1:0]   WADDR,
    input  logic [WIDTH-1:0]    WDATA,
    input  logic                RE_A,
    input  logic [ADDR_W-1:0]   RADDR_A,
    input  logic                RE_B,
    input  logic [ADDR_W-1:0]   RADDR_B,
    output logic [WIDTH-1:0]    OUT_A,
    output logic [WIDTH-1:0]    OUT_B,
    output logic                VALID_A,
    output logic                VALID_B,
    output logic [NUM_REGS-1:0] WSTROBE
);
    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wen;
    logic [WIDTH-1:0]    out_a_q, out_a_d;
    logic [WIDTH-1:0]    out_b_q, out_b_d;
    logic                valid_a_q, valid_b_q;
    logic [NUM_REGS-1:0] wstrobe_q;

    write_decode_16 #(.ZERO_REG(ZERO_REG)) u_wdec (
        .we_i    (WE),
        .waddr_i (WADDR),
        .wen_o   (wen)
    );

    // Bypass keys off the decoded enable, so a dropped write to register 0 is never forwarded.
    always_comb begin
        out_a_d = out_a_q;
        if (RE_A) begin
            out_a_d = wen[RADDR_A] ? WDATA : regs_q[RADDR_A];
            if (ZERO_REG && (RADDR_A == '0)) begin
                out_a_d = '0;
            end
        end
    end

    always_comb begin
        out_b_d = out_b_q;
        if (RE_B) begin
            out_b_d = wen[RADDR_B] ? WDATA : regs_q[RADDR_B];
            if (ZERO_REG && (RADDR_B == '0)) begin
                out_b_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= WIDTH'(RESET_VAL);
            end
            out_a_q   <= WIDTH'(RESET_VAL);
            out_b_q   <= WIDTH'(RESET_VAL);
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            wstrobe_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wen[i]) begin
                    regs_q[i] <= WDATA;
                end
            end
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            valid_a_q <= RE_A;
            valid_b_q <= RE_B;
            wstrobe_q <= wen;
        end
    end

    assign OUT_A   = out_a_q;
    assign OUT_B   = out_b_q;
    assign VALID_A = valid_a_q;
    assign VALID_B = valid_b_q;
    assign WSTROBE = wstrobe_q;
endmodule

// File: tb/tb_register_bank_16.sv
// Bench for register_bank_16: two instances (ZERO_REG=0 and 1) driven in lockstep against a behavioural model.
`timescale 1ns/1ps
module tb_register_bank_16;
    logic       CLK = 1'b0;
    logic       RST;
    logic       WE, RE_A, RE_B;
    logic [3:0] WADDR, RADDR_A, RADDR_B;
    logic [7:0] WDATA;

    logic [1:0][7:0]  out_a, out_b;
    logic [1:0]       valid_a, valid_b;
    logic [1:0][15:0] wstb;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Model state: register contents and expected outputs, index 0 = ZERO_REG off, 1 = on.
    logic [7:0]       mem [2][16];
    logic [1:0][7:0]  exp_oa, exp_ob;
    logic [1:0]       exp_va, exp_vb;
    logic [1:0][15:0] exp_ws;

    register_bank_16 #(.WIDTH(8), .ZERO_REG(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RE_A(RE_A), .RADDR_A(RADDR_A), .RE_B(RE_B), .RADDR_B(RADDR_B),
        .OUT_A(out_a[0]), .OUT_B(out_b[0]), .VALID_A(valid_a[0]), .VALID_B(valid_b[0]),
        .WSTROBE(wstb[0])
    );

    register_bank_16 #(.WIDTH(8), .ZERO_REG(1'b1)) dut1 (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RE_A(RE_A), .RADDR_A(RADDR_A), .RE_B(RE_B), .RADDR_B(RADDR_B),
        .OUT_A(out_a[1]), .OUT_B(out_b[1]), .VALID_A(valid_a[1]), .VALID_B(valid_b[1]),
        .WSTROBE(wstb[1])
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int z, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (ZERO_REG=%0d) t=%0t: got %h expected %h", name, z, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input int z, input logic [3:0] a, input bit wr_ok,
                                              input logic [3:0] wa, input logic [7:0] wd);
        if (z == 1 && a == 4'd0) return 8'h00;
        if (wr_ok && a == wa) return wd;
        return mem[z][a];
    endfunction

    task automatic model_clear();
        for (int z = 0; z < 2; z++) begin
            for (int k = 0; k < 16; k++) mem[z][k] = 8'h00;
            exp_oa[z] = 8'h00; exp_ob[z] = 8'h00;
            exp_va[z] = 1'b0;  exp_vb[z] = 1'b0;
            exp_ws[z] = 16'h0000;
        end
    endtask

    // Drive one cycle of requests, then advance the model past the edge that samples them.
    task automatic step(input bit we, input logic [3:0] wa, input logic [7:0] wd,
                        input bit ra_en, input logic [3:0] ra, input bit rb_en, input logic [3:0] rb);
        logic [1:0][7:0] n_oa, n_ob;
        bit   [1:0]      ok;
        WE = we; WADDR = wa; WDATA = wd;
        RE_A = ra_en; RADDR_A = ra; RE_B = rb_en; RADDR_B = rb;
        for (int z = 0; z < 2; z++) begin
            ok[z]   = we && !(z == 1 && wa == 4'd0);
            n_oa[z] = ra_en ? model_read(z, ra, ok[z], wa, wd) : exp_oa[z];
            n_ob[z] = rb_en ? model_read(z, rb, ok[z], wa, wd) : exp_ob[z];
        end
        @(posedge CLK);
        #1;
        for (int z = 0; z < 2; z++) begin
            exp_oa[z] = n_oa[z];
            exp_ob[z] = n_ob[z];
            exp_va[z] = ra_en;
            exp_vb[z] = rb_en;
            exp_ws[z] = ok[z] ? (16'h0001 << wa) : 16'h0000;
            if (ok[z]) mem[z][wa] = wd;
        end
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int z = 0; z < 2; z++) begin
            chk({tag, "_OUT_A"},   z, {8'h00, out_a[z]},   16'h0000);
            chk({tag, "_OUT_B"},   z, {8'h00, out_b[z]},   16'h0000);
            chk({tag, "_VALID_A"}, z, {15'h0, valid_a[z]}, 16'h0000);
            chk({tag, "_VALID_B"}, z, {15'h0, valid_b[z]}, 16'h0000);
            chk({tag, "_WSTROBE"}, z, wstb[z],             16'h0000);
        end
    endtask

    // Reset asserted between edges while a write to index 5 is presented; held across one edge.
    task automatic async_reset();
        WE = 1'b1; WADDR = 4'd5; WDATA = 8'h77;
        RE_A = 1'b0; RE_B = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        model_clear();
        chk_all_zero("midreset");
        @(posedge CLK);
        #2;
        WE = 1'b0;
        RST = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (chk_on) begin
            for (int z = 0; z < 2; z++) begin
                chk("OUT_A",   z, {8'h00, out_a[z]},   {8'h00, exp_oa[z]});
                chk("OUT_B",   z, {8'h00, out_b[z]},   {8'h00, exp_ob[z]});
                chk("VALID_A", z, {15'h0, valid_a[z]}, {15'h0, exp_va[z]});
                chk("VALID_B", z, {15'h0, valid_b[z]}, {15'h0, exp_vb[z]});
                chk("WSTROBE", z, wstb[z],             exp_ws[z]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; WE = 1'b0; WADDR = '0; WDATA = '0;
        RE_A = 1'b0; RADDR_A = '0; RE_B = 1'b0; RADDR_B = '0;
        model_clear();
        #3;
        chk_all_zero("reset");
        @(posedge CLK);
        #2;
        RST = 1'b0;
        chk_on = 1'b1;

        for (int k = 0; k < 16; k++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(k), 1'b1, 4'(15 - k));
        for (int z = 0; z < 2; z++) chk("post_reset_read", z, {8'h00, out_a[z]}, 16'h0000);

        step(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0, 4'd0);
        for (int z = 0; z < 2; z++) chk("wstrobe_idx3", z, wstb[z], 16'h0008);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0, 4'd0);
        for (int z = 0; z < 2; z++) begin
            chk("readback_idx3", z, {8'h00, out_a[z]}, 16'h00A5);
            chk("readback_valid", z, {15'h0, valid_a[z]}, 16'h0001);
            chk("wstrobe_cleared", z, wstb[z], 16'h0000);
        end
        idle();
        for (int z = 0; z < 2; z++) begin
            chk("valid_pulse_end", z, {15'h0, valid_a[z]}, 16'h0000);
            chk("out_hold", z, {8'h00, out_a[z]}, 16'h00A5);
        end

        step(1'b1, 4'd7, 8'h3C, 1'b1, 4'd7, 1'b1, 4'd7);
        for (int z = 0; z < 2; z++) begin
            chk("bypass_A", z, {8'h00, out_a[z]}, 16'h003C);
            chk("bypass_B", z, {8'h00, out_b[z]}, 16'h003C);
        end

        step(1'b1, 4'd0, 8'hFF, 1'b0, 4'd0, 1'b0, 4'd0);
        chk("zero_wstrobe", 0, wstb[0], 16'h0001);
        chk("zero_wstrobe", 1, wstb[1], 16'h0000);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 1'b0, 4'd0);
        chk("zero_read", 0, {8'h00, out_a[0]}, 16'h00FF);
        chk("zero_read", 1, {8'h00, out_a[1]}, 16'h0000);

        for (int k = 0; k < 16; k++) step(1'b1, 4'(k), 8'(8'h10 + k), 1'b0, 4'd0, 1'b0, 4'd0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 4'd0, 8'h00, 1'b1, 4'(k), 1'b1, 4'(15 - k));
            chk("sweep_A", 0, {8'h00, out_a[0]}, 16'(8'h10 + k));
            chk("sweep_B", 0, {8'h00, out_b[0]}, 16'(8'h10 + 15 - k));
        end
        idle();
        chk("sweep_hold_A", 0, {8'h00, out_a[0]}, 16'h001F);
        chk("sweep_hold_B", 1, {8'h00, out_b[1]}, 16'h0000);

        async_reset();
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b1, 4'd3);
        for (int z = 0; z < 2; z++) begin
            chk("reset_drops_write", z, {8'h00, out_a[z]}, 16'h0000);
            chk("reset_clears_regs", z, {8'h00, out_b[z]}, 16'h0000);
        end

        for (int n = 0; n < 600; n++) begin
            step(1'($urandom), 4'($urandom), 8'($urandom),
                 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
        end
        idle();
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/register_bank_16.md
# register_bank_16

Sixteen-entry, 8-bit register bank that stores the values the CPU datapath reads through its 16-way operand multiplexers and writes through its 16-way enable demultiplexers. It has one synchronous write port with a decoded one-hot write enable, and two independent registered read ports (A and B) with write-to-read bypass. It sits between the ALU result bus and the ALU operand inputs.

## Interface
- WIDTH, 8, data width of every register and port.
- ZERO_REG, 0, when 1 register 0 is hard-wired to zero and writes to it are discarded.

- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  reset, asynchronous and active-high.
- WE  input  1  write request, sampled on the CLK rising edge.
- WADDR  input  4  write register index.
- WDATA  input  WIDTH  write data.
- RE_A  input  1  read request, port A.
- RADDR_A  input  4  read index, port A.
- RE_B  input  1  read request, port B.
- RADDR_B  input  4  read index, port B.
- OUT_A  output  WIDTH  registered read data, port A.
- OUT_B  output  WIDTH  registered read data, port B.
- VALID_A  output  1  one-cycle pulse: OUT_A updated this cycle.
- VALID_B  output  1  one-cycle pulse: OUT_B updated this cycle.
- WSTROBE  output  16  one-hot copy of the write enable committed on the last edge; all zero when no write was committed.

## Operation
- Storage: 16 x WIDTH flops. Register k loads WDATA on an edge where WE=1 and WADDR=k.
- Write decode: 4-to-16 one-hot enable, gated by WE.
- ZERO_REG=1 behaviour:
  - A write to index 0 is dropped and produces WSTROBE=0.
  - A read of index 0 always returns 0.
- Read: on an edge with RE_x=1, OUT_x loads the selected register and VALID_x is 1 for the following cycle.
- With RE_x=0, OUT_x holds its last value and VALID_x is 0.
- Bypass: a read sampled on the same edge as a committed write to the same index returns WDATA, never the old contents. This applies to either port or both ports.
- Both ports may read the same index in the same cycle; both return identical data.
- Out-of-range indices do not exist, because the index is 4 bits covering 16 entries.
- No backpressure. Every request is accepted every cycle.

## Timing
- Reset (RST=1, asynchronous): all 16 registers = 0, OUT_A = OUT_B = 0, VALID_A = VALID_B = 0, WSTROBE = 0.
- Reset is honoured mid-cycle without waiting for CLK. The first write or read takes effect on the first rising edge after RST deasserts.
- Write latency: WDATA is visible in the storage flops 1 cycle after the edge. A registered read of it issued on the next edge yields it at cycle n+2.
- Read latency: request sampled at edge n; OUT_x and VALID_x are valid during cycle n+1.
- Bypass makes the effective read-after-write latency 1 cycle when the read and the write are on the same edge.
- WSTROBE is registered and asserted for exactly 1 cycle after each committed write.
- Back-to-back writes to the same index: the last write wins. Each write produces its own WSTROBE pulse.

## Structure
- Shared package `regbank_pkg`:
  - NUM_REGS = 16
  - ADDR_W = 4
  - localparam for the reset value (0)
  - function `onehot16(addr)` returning a 16-bit one-hot vector
- Sub-module `write_decode_16`: WE plus WADDR producing a 16-bit one-hot enable, with ZERO_REG masking of bit 0. It is reused by other write-side blocks.
- Read selection is inline, one 16:1 select per port followed by the bypass compare and the output register. There is no separate sub-module.

## Test plan
- Reset: assert RST asynchronously between edges. All outputs read 0 immediately. Reading every index after release returns 0x00.
- Write and read back: write 0xA5 to index 3, then RE_A at index 3 on the next edge. OUT_A=0xA5 and VALID_A=1 for one cycle. WSTROBE=0x0008 for one cycle after the write.
- Same-edge bypass: WE with WADDR=7 and WDATA=0x3C, together with RE_A=RE_B=1 at index 7. Both OUT_A and OUT_B = 0x3C on the next cycle.
- Zero register: with ZERO_REG=1, write 0xFF to index 0, then read it. OUT_A=0x00 and WSTROBE stays 0x0000.
- With ZERO_REG=0, the same sequence gives OUT_A=0xFF.
- Sweep: write 0x10+k to every index k=0..15, then read pairs (k, 15-k) on ports A and B. Every pair matches, VALID pulses once per read, and OUT holds its value while RE=0.
- Reset mid-operation: assert RST while a write is presented. The write is not committed, and reading that index after release returns 0x00.
